// File: rtl/micro_pkg.sv
// Shared definitions for the microcontroller sequencer: opcodes, sequencer
// states, fault codes and register load-strobe layout.
package micro_pkg;

  localparam int STROBE_W = 6;

  localparam int G0_IDX = 0;
  localparam int G1_IDX = 1;
  localparam int G2_IDX = 2;
  localparam int G3_IDX = 3;
  localparam int P0_IDX = 4;
  localparam int P1_IDX = 5;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MOV  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_MOVI = 4'd7;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_ILLEGAL  = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;
  localparam logic [1:0] FC_CONFLICT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_RETIRE,
    ST_FAULT
  } seq_state_t;

  function automatic logic [15:0] op_onehot(input logic [3:0] op);
    op_onehot = 16'h0001 << op;
  endfunction

endpackage

// File: rtl/ctrl_mux.sv
// One-hot select of 16 per-unit control bundles (6 load strobes, pc_inc,
// imm_out) with a multi-hot flag on the selected load strobes.
module ctrl_mux
  import micro_pkg::*;
(
  input  logic [15:0]            sel,
  input  logic [16*STROBE_W-1:0] reg_in_bus,
  input  logic [15:0]            pc_inc_bus,
  input  logic [15:0]            imm_out_bus,
  output logic [STROBE_W-1:0]    reg_in,
  output logic                   pc_inc,
  output logic                   imm_out,
  output logic                   multi_hot
);

  always_comb begin
    reg_in = '0;
    for (int n = 0; n < 16; n++) begin
      reg_in = reg_in | (reg_in_bus[n*STROBE_W +: STROBE_W] & {STROBE_W{sel[n]}});
    end
  end

  assign pc_inc  = |(pc_inc_bus & sel);
  assign imm_out = |(imm_out_bus & sel);

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_hot = (reg_in & (reg_in - STROBE_W'(1))) != '0;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute/retire sequencer that grants one execution unit at a
// time and guards the shared register bus against faulty units.
module instr_sequencer
  import micro_pkg::*;
#(
  parameter logic [15:0] OP_MASK = 16'h00FF,
  parameter int          TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  output logic                   mem_req,
  input  logic                   mem_valid,
  input  logic [15:0]            mem_rdata,
  output logic [15:0]            ir,
  output logic [15:0]            unit_start,
  input  logic [15:0]            unit_done,
  input  logic [15:0]            unit_pc_inc,
  input  logic [15:0]            unit_imm_out,
  input  logic [16*STROBE_W-1:0] unit_reg_in,
  output logic [STROBE_W-1:0]    reg_in,
  output logic                   pc_inc,
  output logic                   imm_out,
  output logic                   busy,
  output logic                   fault,
  output logic [1:0]             fault_code
);

  seq_state_t          state;
  logic [15:0]         grant;
  logic [7:0]          exec_cnt;
  logic [7:0]          cnt_next;
  logic                in_exec;
  logic [15:0]         sel;
  logic [STROBE_W-1:0] mux_reg_in;
  logic                mux_pc_inc;
  logic                mux_imm_out;
  logic                mux_multi;
  logic                granted_done;

  assign in_exec = (state == ST_EXEC);
  assign sel     = in_exec ? grant : 16'h0000;

  ctrl_mux u_ctrl_mux (
    .sel         (sel),
    .reg_in_bus  (unit_reg_in),
    .pc_inc_bus  (unit_pc_inc),
    .imm_out_bus (unit_imm_out),
    .reg_in      (mux_reg_in),
    .pc_inc      (mux_pc_inc),
    .imm_out     (mux_imm_out),
    .multi_hot   (mux_multi)
  );

  // Outputs are decoded from registered state and grant only, so an
  // asynchronous reset silences the bus immediately.
  assign unit_start   = sel;
  assign reg_in       = mux_multi ? '0 : mux_reg_in;
  assign pc_inc       = mux_pc_inc;
  assign imm_out      = mux_imm_out;
  assign mem_req      = (state == ST_FETCH);
  assign busy         = (state != ST_IDLE) && (state != ST_FAULT);
  assign fault        = (state == ST_FAULT);
  assign granted_done = |(unit_done & grant);
  assign cnt_next     = (exec_cnt == 8'hFF) ? exec_cnt : exec_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ir         <= 16'h0000;
      grant      <= 16'h0000;
      exec_cnt   <= 8'd0;
      fault_code <= FC_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (mem_valid) begin
            ir    <= mem_rdata;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (!OP_MASK[ir[15:12]]) begin
            fault_code <= FC_ILLEGAL;
            state      <= ST_FAULT;
          end else begin
            grant    <= op_onehot(ir[15:12]);
            exec_cnt <= 8'd0;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          exec_cnt <= cnt_next;
          // A conflict outranks done: the bus was already corrupted this cycle.
          if (mux_multi) begin
            fault_code <= FC_CONFLICT;
            state      <= ST_FAULT;
          end else if (granted_done) begin
            state <= ST_RETIRE;
          end else if (cnt_next == 8'(TIMEOUT)) begin
            fault_code <= FC_TIMEOUT;
            state      <= ST_FAULT;
          end
        end
        ST_RETIRE: begin
          grant <= 16'h0000;
          state <= run ? ST_FETCH : ST_IDLE;
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a per-cycle reference model and
// hand-computed spot checks.
module tb_instr_sequencer;
  import micro_pkg::*;

  localparam int TMO = 15;
  localparam int M_IDLE = 0, M_FETCH = 1, M_DECODE = 2, M_EXEC = 3, M_RETIRE = 4, M_FAULT = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        mem_req;
  logic        mem_valid = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] ir;
  logic [15:0] unit_start;
  logic [15:0] unit_done = '0;
  logic [15:0] unit_pc_inc = '0;
  logic [15:0] unit_imm_out = '0;
  logic [95:0] unit_reg_in = '0;
  logic [5:0]  reg_in;
  logic        pc_inc;
  logic        imm_out;
  logic        busy;
  logic        fault;
  logic [1:0]  fault_code;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .mem_req      (mem_req),
    .mem_valid    (mem_valid),
    .mem_rdata    (mem_rdata),
    .ir           (ir),
    .unit_start   (unit_start),
    .unit_done    (unit_done),
    .unit_pc_inc  (unit_pc_inc),
    .unit_imm_out (unit_imm_out),
    .unit_reg_in  (unit_reg_in),
    .reg_in       (reg_in),
    .pc_inc       (pc_inc),
    .imm_out      (imm_out),
    .busy         (busy),
    .fault        (fault),
    .fault_code   (fault_code)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase, latched instruction, EXEC cycle count, fault code.
  int          m_phase = M_IDLE;
  logic [15:0] m_ir = '0;
  logic [1:0]  m_code = 2'b00;
  int          m_n = 0;
  logic [15:0] m_mask = 16'h00FF;

  always @(negedge clk) begin
    logic [3:0]  op;
    logic [5:0]  s;
    logic [15:0] e_start;
    logic [5:0]  e_reg;
    logic        e_pc;
    logic        e_imm;
    logic        conflict;
    if (!rst_n) begin
      m_phase = M_IDLE;
      m_ir    = '0;
      m_code  = 2'b00;
      m_n     = 0;
    end
    op       = m_ir[15:12];
    s        = unit_reg_in[int'(op)*6 +: 6];
    conflict = ($countones(s) > 1);
    e_start  = '0;
    e_reg    = '0;
    e_pc     = 1'b0;
    e_imm    = 1'b0;
    if (m_phase == M_EXEC) begin
      e_start = 16'h0001 << op;
      e_reg   = conflict ? 6'b000000 : s;
      e_pc    = unit_pc_inc[op];
      e_imm   = unit_imm_out[op];
    end
    check("model_ir", 32'(ir), 32'(m_ir));
    check("model_unit_start", 32'(unit_start), 32'(e_start));
    check("model_reg_in", 32'(reg_in), 32'(e_reg));
    check("model_pc_inc", 32'(pc_inc), 32'(e_pc));
    check("model_imm_out", 32'(imm_out), 32'(e_imm));
    check("model_mem_req", 32'(mem_req), 32'(m_phase == M_FETCH));
    check("model_busy", 32'(busy), 32'(m_phase != M_IDLE && m_phase != M_FAULT));
    check("model_fault", 32'(fault), 32'(m_phase == M_FAULT));
    check("model_fault_code", 32'(fault_code), 32'(m_code));
    if (rst_n) begin
      case (m_phase)
        M_IDLE:   if (run) m_phase = M_FETCH;
        M_FETCH:  if (mem_valid) begin m_ir = mem_rdata; m_phase = M_DECODE; end
        M_DECODE: begin
          if (!m_mask[op]) begin m_code = 2'b01; m_phase = M_FAULT; end
          else begin m_n = 0; m_phase = M_EXEC; end
        end
        M_EXEC: begin
          if (m_n < 255) m_n++;
          if (conflict) begin m_code = 2'b11; m_phase = M_FAULT; end
          else if (unit_done[op]) m_phase = M_RETIRE;
          else if (m_n == TMO) begin m_code = 2'b10; m_phase = M_FAULT; end
        end
        M_RETIRE: m_phase = run ? M_FETCH : M_IDLE;
        default:  m_phase = M_FAULT;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_units();
    unit_done    = '0;
    unit_pc_inc  = '0;
    unit_imm_out = '0;
    unit_reg_in  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    clear_units();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_start(input string name);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (unit_start == 16'h0000 && k < 30);
    check(name, 32'(unit_start != 16'h0000), 32'd1);
  endtask

  initial begin
    int n;
    int k;
    logic start_seen;

    // Reset and idle hold
    sample();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_unit_start", 32'(unit_start), 32'd0);
    check("rst_reg_in", 32'(reg_in), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_ir", 32'(ir), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_mem_req", 32'(mem_req), 32'd0);

    // MOVI with done held into RETIRE and a noisy non-granted unit
    run = 1'b1;
    mem_rdata = 16'h7005;
    mem_valid = 1'b1;
    wait_start("movi_start_wait");
    mem_valid = 1'b0;
    step();
    unit_reg_in[3*6 +: 6] = 6'b111111;
    unit_pc_inc[3] = 1'b1;
    unit_done[3] = 1'b1;
    sample();
    check("movi_noise_reg_in", 32'(reg_in), 32'd0);
    check("movi_noise_pc_inc", 32'(pc_inc), 32'd0);
    step();
    clear_units();
    unit_reg_in[7*6 +: 6] = 6'b000001;
    unit_imm_out[7] = 1'b1;
    unit_done[7] = 1'b1;
    sample();
    check("movi_unit_start", 32'(unit_start), 32'h0080);
    check("movi_reg_in", 32'(reg_in), 32'(6'b000001));
    check("movi_imm_out", 32'(imm_out), 32'd1);
    step();
    unit_reg_in = '0;
    unit_imm_out = '0;
    sample();
    check("movi_retire_start", 32'(unit_start), 32'd0);
    check("movi_retire_busy", 32'(busy), 32'd1);
    check("movi_retire_mem_req", 32'(mem_req), 32'd0);
    step();
    unit_done = '0;
    sample();
    check("movi_refetch", 32'(mem_req), 32'd1);
    step();
    step();
    sample();
    check("movi_single_retire", 32'(mem_req), 32'd1);
    check("movi_ir", 32'(ir), 32'h7005);

    // Illegal opcode from the pending fetch
    step();
    mem_rdata = 16'hF000;
    mem_valid = 1'b1;
    start_seen = 1'b0;
    k = 0;
    while (!fault && k < 10) begin
      step();
      if (unit_start != 16'h0000) start_seen = 1'b1;
      k++;
    end
    check("illegal_fault", 32'(fault), 32'd1);
    check("illegal_code", 32'(fault_code), 32'(2'b01));
    check("illegal_no_start", 32'(start_seen), 32'd0);
    repeat (3) step();
    check("illegal_sticky", 32'(fault_code), 32'(2'b01));
    check("illegal_mem_req", 32'(mem_req), 32'd0);
    check("illegal_busy", 32'(busy), 32'd0);

    // Hung unit: opcode 2 never signals done
    do_reset();
    run = 1'b1;
    mem_rdata = 16'h2000;
    mem_valid = 1'b1;
    wait_start("hung_start_wait");
    mem_valid = 1'b0;
    unit_reg_in[2*6 +: 6] = 6'b000100;
    unit_pc_inc[2] = 1'b1;
    n = 0;
    k = 0;
    while (!fault && k < 40) begin
      sample();
      if (unit_start != 16'h0000) n++;
      k++;
    end
    check("hung_exec_cycles", 32'(n), 32'd15);
    check("hung_code", 32'(fault_code), 32'(2'b10));
    check("hung_reg_in", 32'(reg_in), 32'd0);
    check("hung_pc_inc", 32'(pc_inc), 32'd0);
    check("hung_unit_start", 32'(unit_start), 32'd0);

    // Strobe conflict on the granted unit
    do_reset();
    run = 1'b1;
    mem_rdata = 16'h1234;
    mem_valid = 1'b1;
    wait_start("conf_start_wait");
    mem_valid = 1'b0;
    unit_reg_in[1*6 +: 6] = 6'b000100;
    unit_pc_inc[1] = 1'b1;
    unit_reg_in[5*6 +: 6] = 6'b110000;
    unit_done[5] = 1'b1;
    sample();
    check("conf_ok_reg_in", 32'(reg_in), 32'(6'b000100));
    check("conf_ok_pc_inc", 32'(pc_inc), 32'd1);
    check("conf_ok_start", 32'(unit_start), 32'h0002);
    step();
    unit_reg_in[1*6 +: 6] = 6'b000011;
    sample();
    check("conf_forced_zero", 32'(reg_in), 32'd0);
    check("conf_not_yet", 32'(fault), 32'd0);
    step();
    check("conf_fault", 32'(fault), 32'd1);
    check("conf_code", 32'(fault_code), 32'(2'b11));
    check("conf_pc_inc", 32'(pc_inc), 32'd0);

    // Asynchronous reset mid-EXEC, then recovery
    do_reset();
    run = 1'b1;
    mem_rdata = 16'h7000;
    mem_valid = 1'b1;
    wait_start("arst_start_wait");
    mem_valid = 1'b0;
    unit_reg_in[7*6 +: 6] = 6'b000010;
    unit_pc_inc[7] = 1'b1;
    sample();
    check("arst_before", 32'(reg_in), 32'(6'b000010));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_reg_in", 32'(reg_in), 32'd0);
    check("arst_pc_inc", 32'(pc_inc), 32'd0);
    check("arst_unit_start", 32'(unit_start), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ir", 32'(ir), 32'd0);
    step();
    clear_units();
    run = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("recov_idle", 32'(busy), 32'd0);
    run = 1'b1;
    mem_rdata = 16'h7005;
    mem_valid = 1'b1;
    wait_start("recov_start_wait");
    mem_valid = 1'b0;
    run = 1'b0;
    unit_reg_in[7*6 +: 6] = 6'b000001;
    unit_imm_out[7] = 1'b1;
    unit_done[7] = 1'b1;
    step();
    clear_units();
    step();
    sample();
    check("recov_done_busy", 32'(busy), 32'd0);
    check("recov_fault", 32'(fault), 32'd0);
    check("recov_ir", 32'(ir), 32'h7005);

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Top-level instruction sequencer for the microcontroller. It fetches a 16-bit instruction, decodes the 4-bit opcode and starts exactly one per-opcode execution FSM (MOVI, MOV, ADD, …). It then multiplexes that unit's bus-control strobes onto the shared datapath, waits for the unit's `done`, and retires before fetching again. It also guards the shared register bus against illegal opcodes, hung units and multi-driver strobes.

## Interface
Parameters:
- `OP_MASK`, default 16'h00FF: bit n set means opcode n has an execution unit; other opcodes fault.
- `TIMEOUT`, default 15: maximum EXEC cycles without `done` before fault; range 1–255.

Ports:
- `clk` in, 1: single clock, rising edge.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `run` in, 1: enables fetching; sampled in IDLE and RETIRE.
- `mem_req` out, 1: instruction fetch request.
- `mem_valid` in, 1: fetch data valid.
- `mem_rdata` in, 16: instruction word.
- `ir` out, 16: latched instruction, broadcast to all units.
- `unit_start` out, 16: one-hot enable for the unit of opcode `ir[15:12]`.
- `unit_done` in, 16: per-unit done.
- `unit_pc_inc` in, 16: per-unit PC increment request.
- `unit_imm_out` in, 16: per-unit immediate-to-bus request.
- `unit_reg_in` in, 96: per-unit 6-bit load strobes {P1,P0,G3,G2,G1,G0}; unit n occupies bits [6n+5:6n].
- `reg_in` out, 6: muxed load strobes to G0..G3, P0, P1.
- `pc_inc` out, 1: muxed PC increment.
- `imm_out` out, 1: muxed immediate enable.
- `busy` out, 1: high in every state except IDLE and FAULT.
- `fault` out, 1: sticky fault flag.
- `fault_code` out, 2: 01 illegal opcode, 10 timeout, 11 strobe conflict.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, RETIRE, FAULT.
- IDLE: go to FETCH when `run`=1.
- FETCH: `mem_req`=1 until `mem_valid`=1. On that edge `ir`←`mem_rdata` and the state goes to DECODE. There is no fetch timeout.
- DECODE, 1 cycle: if `OP_MASK[ir[15:12]]`=0, go to FAULT with code 01. Otherwise latch the one-hot grant, clear the timeout counter and go to EXEC.
- EXEC: `unit_start`=grant. `reg_in`, `pc_inc` and `imm_out` come from the granted unit only and are combinational through the grant register. Other units' inputs are ignored.
  - `unit_done[grant]`=1: go to RETIRE on the next edge. Done samples in the same cycle as strobes still pass that cycle's strobes.
  - Counter reaches `TIMEOUT` with no done: go to FAULT, code 10.
  - Granted `reg_in` has more than one bit set in any cycle: go to FAULT, code 11, and force `reg_in`=0 in that cycle.
- RETIRE, 1 cycle: `unit_start`=0 and all muxed outputs are 0, which returns the unit to its idle state. A unit that holds `done` for extra cycles is ignored. Then go to FETCH if `run`=1, else IDLE.
- FAULT: all strobes and `unit_start` are 0 and `mem_req`=0. `fault`=1 and `fault_code` is held. Only reset exits this state.
- Dropping `run` mid-instruction takes effect only at RETIRE; the current instruction completes.

## Timing
- Reset values: state IDLE; `ir`=0, `unit_start`=0, `reg_in`=0, `pc_inc`=0, `imm_out`=0, `mem_req`=0, `busy`=0, `fault`=0, `fault_code`=00. Reset asserts asynchronously mid-operation and clears everything immediately, including in-flight strobes.
- Minimum instruction length: FETCH(1, `mem_valid` already high) + DECODE(1) + EXEC(k) + RETIRE(1), so 3+k cycles.
- `unit_start` rises on the first EXEC cycle and falls on the RETIRE cycle.
- Muxed outputs have zero-cycle latency from the unit inputs during EXEC. Outside EXEC they are 0.
- Timeout counter is 8-bit, saturating, and counts EXEC cycles starting at 1.

## Structure
- Shared package `micro_pkg` contains:
  - opcode constants (`OP_MOVI`=4'd7, etc.);
  - sequencer state enum;
  - fault code constants;
  - strobe bit indices `G0_IDX`..`P1_IDX`;
  - `STROBE_W`=6.
- One sub-module, `ctrl_mux`: one-hot-select of 16 control bundles (6+1+1 bits) plus a multi-hot detect on the selected strobes.

## Test plan
- Reset: hold `rst_n`=0 → every output 0, `busy`=0. Release with `run`=0 → stays IDLE.
- MOVI: `run`=1, `mem_rdata`=16'h7005, `mem_valid`=1. Unit 7 asserts `reg_in`=6'b000001 and `imm_out`=1 in EXEC cycle 3 with `done`=1 in cycles 3–4 → `unit_start`=16'h0080. Muxed outputs match unit 7 in cycle 3. Exactly one RETIRE, then `mem_req`=1 again.
- Illegal opcode: fetch 16'hF000 with default `OP_MASK` → `fault`=1, `fault_code`=01 after DECODE, `unit_start` never nonzero.
- Hung unit: opcode 2, `unit_done`=0 → FAULT with code 10 after 15 EXEC cycles; all strobes 0.
- Strobe conflict: granted unit drives `reg_in`=6'b000011 → that cycle's `reg_in`=0, then FAULT with code 11. Non-granted unit driving strobes or done has no effect.
- Reset mid-EXEC: drop `rst_n` between edges while `reg_in`≠0 → outputs 0 without waiting for a clock edge. Recovery restarts from IDLE.
